// File: rtl/act_fn_pipe.sv
// rtl/act_fn_pipe.sv - three-stage fixed-point activation unit (sigmoid, sigmoid', tanh, bypass)
// with valid/ready backpressure, a sideband tag and a saturation flag.
module act_fn_pipe #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat
);

  localparam logic [W-1:0] C_ONE   = W'(1)  << FRAC;
  localparam logic [W-1:0] C_FIVE  = W'(5)  << FRAC;
  localparam logic [W-1:0] C_2P375 = W'(19) << (FRAC - 3);
  localparam logic [W-1:0] C_0P843 = W'(27) << (FRAC - 5);
  localparam logic [W-1:0] C_0P625 = W'(5)  << (FRAC - 3);
  localparam logic [W-1:0] C_HALF  = W'(1)  << (FRAC - 1);
  localparam logic [W-1:0] C_MAXP  = {1'b0, {(W-1){1'b1}}};

  localparam logic [1:0] M_SIG   = 2'd0;
  localparam logic [1:0] M_DERIV = 2'd1;
  localparam logic [1:0] M_TANH  = 2'd2;

  logic             r1_valid, r2_valid, r3_valid;
  logic             r1_neg;
  logic [W-1:0]     r1_a, r1_x, r2_s, r2_x, r3_data;
  logic [1:0]       r1_seg, r1_mode, r2_mode;
  logic [TAG_W-1:0] r1_tag, r2_tag, r3_tag;
  logic             r2_sat, r3_sat;

  logic             w_rdy1, w_rdy2, w_rdy3;
  logic             w_neg;
  logic [W-1:0]     w_abs, w_abs_sat, w_mag;
  logic [1:0]       w_seg;
  logic [W-1:0]     w_p, w_s, w_comp, w_deriv, w_tanh, w_res;
  logic [2*W-1:0]   w_prod;
  logic             w_sat3;

  // Each stage accepts when it is empty or its contents move on this edge.
  assign w_rdy3   = !r3_valid || out_ready;
  assign w_rdy2   = !r2_valid || w_rdy3;
  assign w_rdy1   = !r1_valid || w_rdy2;
  assign in_ready = w_rdy1;

  assign out_valid = r3_valid;
  assign out_data  = r3_data;
  assign out_tag   = r3_tag;
  assign out_sat   = r3_sat;

  // Stage 1: saturating magnitude (doubled for tanh) and segment choice.
  assign w_neg     = in_data[W-1];
  assign w_abs     = w_neg ? (W'(0) - in_data) : in_data;
  assign w_abs_sat = w_abs[W-1] ? C_MAXP : w_abs;
  assign w_mag     = (in_mode == M_TANH)
                   ? (w_abs_sat[W-2] ? C_MAXP : {w_abs_sat[W-2:0], 1'b0})
                   : w_abs_sat;

  always_comb begin
    w_seg = 2'd0;
    if (w_mag >= C_FIVE)       w_seg = 2'd3;
    else if (w_mag >= C_2P375) w_seg = 2'd2;
    else if (w_mag >= C_ONE)   w_seg = 2'd1;
  end

  // Stage 2: piecewise-linear sigmoid of the magnitude, mirrored for negatives.
  always_comb begin
    w_p = C_ONE;
    case (r1_seg)
      2'd2:    w_p = (r1_a >> 5) + C_0P843;
      2'd1:    w_p = (r1_a >> 3) + C_0P625;
      2'd0:    w_p = (r1_a >> 2) + C_HALF;
      default: w_p = C_ONE;
    endcase
  end
  assign w_s = r1_neg ? (C_ONE - w_p) : w_p;

  // Stage 3: mode mapping; s is always within [0, 1.0] here.
  assign w_comp  = C_ONE - r2_s;
  assign w_prod  = {{W{1'b0}}, r2_s} * {{W{1'b0}}, w_comp};
  assign w_deriv = W'(w_prod >> FRAC);
  assign w_tanh  = {r2_s[W-2:0], 1'b0} - C_ONE;

  always_comb begin
    w_res  = r2_x;
    w_sat3 = r2_sat;
    case (r2_mode)
      M_SIG:   w_res = (r2_s == '0) ? W'(1) : r2_s;
      M_DERIV: w_res = w_deriv;
      M_TANH:  w_res = w_tanh;
      default: begin
        w_res  = r2_x;
        w_sat3 = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_neg   <= 1'b0;
      r1_a     <= '0;
      r1_x     <= '0;
      r1_seg   <= '0;
      r1_mode  <= '0;
      r1_tag   <= '0;
      r2_valid <= 1'b0;
      r2_s     <= '0;
      r2_x     <= '0;
      r2_mode  <= '0;
      r2_tag   <= '0;
      r2_sat   <= 1'b0;
      r3_valid <= 1'b0;
      r3_data  <= '0;
      r3_tag   <= '0;
      r3_sat   <= 1'b0;
    end else begin
      if (w_rdy1) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_neg  <= w_neg;
          r1_a    <= w_mag;
          r1_x    <= in_data;
          r1_seg  <= w_seg;
          r1_mode <= in_mode;
          r1_tag  <= in_tag;
        end
      end
      if (w_rdy2) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_s    <= w_s;
          r2_x    <= r1_x;
          r2_mode <= r1_mode;
          r2_tag  <= r1_tag;
          r2_sat  <= (r1_seg == 2'd3);
        end
      end
      if (w_rdy3) begin
        r3_valid <= r2_valid;
        if (r2_valid) begin
          r3_data <= w_res;
          r3_tag  <= r2_tag;
          r3_sat  <= w_sat3;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_fn_pipe.sv
// tb/tb_act_fn_pipe.sv - directed and randomized self-checking bench for act_fn_pipe
// against an arithmetic reference model and an in-order scoreboard.
module tb_act_fn_pipe;
  localparam int W = 32, FRAC = 16, TAG_W = 8;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [W-1:0]     in_data = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid, out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_sat;

  always #5 clk = ~clk;

  act_fn_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  int passed = 0, total = 0, cyc_n = 0, n_out = 0;
  logic [W-1:0]     q_data[$];
  logic [TAG_W-1:0] q_tag[$];
  logic             q_sat[$];
  int               q_cyc[$];
  bit               q_lat[$];
  bit               lat_chk = 1'b0, ovr_en = 1'b0;
  logic [W:0]       ovr = '0;
  logic             hold_v = 1'b0;
  logic [W-1:0]     hold_d;
  logic [TAG_W-1:0] hold_t;
  logic             hold_s;

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [1:0] m);
    longint xi, mag, one, maxp, p, s, r;
    logic   sat;
    one  = longint'(1) << FRAC;
    maxp = (longint'(1) << (W - 1)) - 1;
    xi   = longint'(signed'(x));
    mag  = (xi < 0) ? -xi : xi;
    if (mag > maxp) mag = maxp;
    if (m == 2'd2) begin
      mag = 2 * mag;
      if (mag > maxp) mag = maxp;
    end
    if (mag >= 5 * one)             p = one;
    else if (mag >= (19 * one) / 8) p = mag / 32 + (27 * one) / 32;
    else if (mag >= one)            p = mag / 8 + (5 * one) / 8;
    else                            p = mag / 4 + one / 2;
    s   = (xi < 0) ? one - p : p;
    sat = (mag >= 5 * one);
    case (m)
      2'd0:    r = (s == 0) ? 1 : s;
      2'd1:    r = (s * (one - s)) / one;
      2'd2:    r = 2 * s - one;
      default: begin r = xi; sat = 1'b0; end
    endcase
    return {sat, r[W-1:0]};
  endfunction

  // One clock cycle: drive inputs, then score transfers midway through the low phase.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                     input logic [TAG_W-1:0] t, input logic ordy, output logic acc);
    logic [W:0] e;
    in_valid = v; in_data = d; in_mode = m; in_tag = t; out_ready = ordy;
    #2;
    if (hold_v) begin
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_data", out_data, hold_d);
      check("hold_tag", W'(out_tag), W'(hold_t));
      check("hold_sat", W'(out_sat), W'(hold_s));
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e = ovr_en ? ovr : model(d, m);
      q_data.push_back(e[W-1:0]);
      q_sat.push_back(e[W]);
      q_tag.push_back(t);
      q_cyc.push_back(cyc_n);
      q_lat.push_back(lat_chk);
    end
    if (out_valid && out_ready) begin
      if (q_data.size() == 0) begin
        check("spurious_out", W'(out_valid), W'(0));
      end else begin
        int  c;
        bit  l;
        c = q_cyc.pop_front();
        l = q_lat.pop_front();
        check("out_data", out_data, q_data.pop_front());
        check("out_tag", W'(out_tag), W'(q_tag.pop_front()));
        check("out_sat", W'(out_sat), W'(q_sat.pop_front()));
        if (l) check("latency", W'(cyc_n - c), W'(3));
        n_out++;
      end
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data; hold_t = out_tag; hold_s = out_sat;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 50 && q_data.size() > 0; k++) cyc(1'b0, '0, 2'd0, '0, 1'b1, a);
    check("drain_empty", W'(q_data.size()), W'(0));
  endtask

  logic [W-1:0] dx[14]  = '{32'h00010000, 32'h0, 32'hFFFF0000, 32'h0002C000,
                            32'h00050000, 32'hFFFA0000, 32'h80000000,
                            32'h0, 32'h00010000, 32'h00050000,
                            32'h00008000, 32'hFFFF8000, 32'h00030000, 32'h12345678};
  logic [1:0]   dm[14]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                            2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [W-1:0] de[14]  = '{32'h0000C000, 32'h00008000, 32'h00004000, 32'h0000EE00,
                            32'h00010000, 32'h00000001, 32'h00000001,
                            32'h00004000, 32'h00003000, 32'h0,
                            32'h00008000, 32'hFFFF8000, 32'h00010000, 32'h12345678};
  logic         ds[14]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0};

  function automatic logic [W-1:0] rand_x();
    logic [W-1:0] x;
    x = $urandom;
    if ($urandom_range(0, 2) != 0) begin
      x = W'($urandom_range(0, 12 << FRAC));
      if ($urandom_range(0, 1) == 1) x = W'(0) - x;
    end
    return x;
  endfunction

  initial begin
    logic             acc, v, ordy;
    logic [W-1:0]     x;
    logic [1:0]       m;
    logic [TAG_W-1:0] t;
    int               idx;
    logic [W-1:0]     bx[10];
    logic [1:0]       bm[10];

    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_out_tag", W'(out_tag), W'(0));
    check("rst_out_sat", W'(out_sat), W'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));

    // Directed vectors streamed back to back, each with a latency check.
    lat_chk = 1'b1;
    ovr_en  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      ovr = {ds[i], de[i]};
      cyc(1'b1, dx[i], dm[i], TAG_W'(i), 1'b1, acc);
      check("dir_accept", W'(acc), W'(1));
    end
    ovr_en = 1'b0;
    drain();

    // Mixed modes with tags 0..7.
    for (int i = 0; i < 8; i++) cyc(1'b1, rand_x(), 2'($urandom_range(0, 3)), TAG_W'(i), 1'b1, acc);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 10 samples, out_ready low for 5 cycles mid-stream.
    n_out = 0;
    idx   = 0;
    for (int i = 0; i < 10; i++) begin bx[i] = rand_x(); bm[i] = 2'($urandom_range(0, 3)); end
    for (int j = 0; j < 60 && (idx < 10 || q_data.size() > 0); j++) begin
      ordy = !(j >= 4 && j <= 8);
      cyc(idx < 10, (idx < 10) ? bx[idx] : '0, (idx < 10) ? bm[idx] : 2'd0,
          TAG_W'(8'h40 + idx), ordy, acc);
      if (acc) idx++;
      if (j == 8) check("bp_in_ready_low", W'(in_ready), W'(0));
    end
    check("bp_count", W'(n_out), W'(10));
    drain();

    // Randomized traffic with random valid and ready; samples held until accepted.
    v = 1'b0; x = '0; m = '0; t = '0;
    for (int j = 0; j < 400; j++) begin
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        x = rand_x(); m = 2'($urandom_range(0, 3)); t = TAG_W'($urandom);
      end
      cyc(v, x, m, t, ($urandom_range(0, 9) < 7), acc);
      if (acc) v = 1'b0;
    end
    drain();

    // Asynchronous reset with three samples in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, rand_x(), 2'd0, TAG_W'(i), 1'b0, acc);
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_out_data", out_data, W'(0));
    q_data.delete(); q_tag.delete(); q_sat.delete(); q_cyc.delete(); q_lat.delete();
    hold_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 2'd0, '0, 1'b1, acc);
      check("post_rst_no_out", W'(out_valid), W'(0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
